instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  pulse, loads base_addr, arms the writer; stop  in  1  pulse, returns to IDLE.
REQ-003 SHALL have ports: base_addr  in  14  first IMEM word address; limit  in  14  last writable word address.
REQ-004 SHALL have ports: in_valid  in  1; in_ready  out  1; mnem  in  6  mnemonic code; rs, rt, rd, shamt  in  5 each; imm  in  26  (imm[15:0] for I-type, imm[25:0] for J-type).
REQ-005 SHALL have ports: imem_we  out  1; imem_addr  out  14; imem_wdata  out  32  encoded word.
REQ-006 SHALL have ports: count  out  15  words written since start; full  out  1; err  out  1.

Function
REQ-007 SHALL map mnem codes 0..56 in this order: add addu sub subu mult multu div divu and or xor nor addi addiu andi ori xori lui sll srl sra sllv srlv srav lb lbu lh lhu lw sb sh sw beq bne slt slti sltu sltiu bgez bgtz blez bltz bgezal bltzal j jr jal jalr mfhi mflo mthi mtlo break syscall eret mfc0 mtc0; codes 57..63 SHALL be illegal.
REQ-008 SHALL emit standard MIPS32 opcode/funct per mnemonic, so that the team's decoder recovers the same op_* line.
REQ-009 SHALL force REGIMM rt: bltz 00000, bgez 00001, bltzal 10000, bgezal 10001.
REQ-010 SHALL encode eret as 32'h42000018, mfc0 as op 010000 with rs 00000, and mtc0 as op 010000 with rs 00100; rt and rd SHALL come from the inputs.
REQ-011 SHALL zero every field unused by the format: sll/srl/sra rs=0; other ALU R ops shamt=0; mult/div rd=shamt=0; jr/mthi/mtlo keep rs only; jalr keeps rs and rd; mfhi/mflo keep rd only; break/syscall bits[25:6]=0; lui rs=0; blez/bgtz rt=0.
REQ-012 SHALL implement states IDLE, RUN, FULL and ERR; reset SHALL enter IDLE.
REQ-013 SHALL transition IDLE->RUN on start, loading the address counter with base_addr and clearing count, full and err.
REQ-014 SHALL make a beat accepted when in_valid and in_ready are both high; in_ready SHALL be high only in RUN.
REQ-015 SHALL use a latency of exactly 1 cycle: a beat accepted at edge N SHALL give imem_we=1 for one cycle after edge N, with imem_addr = the counter value at acceptance and the encoded imem_wdata.
REQ-016 SHALL, on each write, increment the address counter and count.
REQ-017 SHALL sustain a throughput of one beat per cycle.
REQ-018 SHALL, when a beat is accepted at address == limit, write that beat, go RUN->FULL, set full and drop in_ready the next cycle; the address SHALL NOT wrap.
REQ-019 SHALL handle base_addr > limit by going straight to FULL on start, with no writes.
REQ-020 SHALL, on stop from RUN, FULL or ERR, go to IDLE; a beat accepted in the same cycle SHALL still be written; full, err and count SHALL hold their values.
REQ-021 SHALL give start priority over stop when both are high; start while in RUN SHALL restart from base_addr.
REQ-022 SHALL hold imem_addr and imem_wdata stable when imem_we=0.

Reset
REQ-023 SHALL, on rst high, immediately force the following regardless of clk: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0.
REQ-024 SHALL discard any pending write when reset is asserted mid-operation; no imem_we pulse SHALL follow reset release without a new start.

Configuration
REQ-025 SHALL, with ENC_ERR_HALT_EN defined, treat an accepted illegal mnem as follows: no write, err=1, state->ERR, in_ready=0 until start or stop.
REQ-026 SHALL, without ENC_ERR_HALT_EN, write an accepted illegal mnem as 32'h00000000 (nop) and advance normally, with err pulsing high for one cycle alongside the write.

Verification
REQ-027 SHALL cover: base_addr=0x010, start, then add rs=1 rt=2 rd=3 -> imem_we at 0x010 with wdata 32'h00221820, count=1.
REQ-028 SHALL cover: back-to-back beats addi rt=8 rs=0 imm=0x0005; j imm=0x0000040; bgezal rs=4 imm=0xFFFF -> wdata 32'h20080005, 32'h08000040, 32'h0491FFFF at consecutive addresses, one per cycle.
REQ-029 SHALL cover: eret, then mtc0 rt=5 rd=12 -> wdata 32'h42000018 then 32'h40856000.
REQ-030 SHALL cover: base_addr=limit=0x3FFF, two beats offered -> one write at 0x3FFF, full=1, second beat not accepted, no wrap.
REQ-031 SHALL cover: mnem=60 with ENC_ERR_HALT_EN defined -> no write, err=1, in_ready=0; without the macro -> write 32'h00000000 with a 1-cycle err pulse.
REQ-032 SHALL cover: rst asserted asynchronously one cycle after an accept -> imem_we=0 immediately, all outputs zero, no write after release.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: turns a stream of (mnemonic, register fields, immediate) beats
// into standard MIPS32 instruction words and writes them to consecutive IMEM
// addresses starting at base_addr and stopping at limit. A write appears one
// cycle after its beat is accepted, and one beat can be accepted every cycle.
// Optional feature macro: ENC_ERR_HALT_EN.
//   Defined:   an accepted illegal mnemonic halts the writer in ERR with no write.
//   Undefined: an illegal mnemonic is written as a nop and err pulses for one cycle.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [13:0] base_addr,
  input  logic [13:0] limit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic        imem_we,
  output logic [13:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [14:0] count,
  output logic        full,
  output logic        err
);

`ifdef ENC_ERR_HALT_EN
  localparam bit HALT_ON_ILLEGAL = 1'b1;
`else
  localparam bit HALT_ON_ILLEGAL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FULL, ERR} state_t;

  state_t      state_reg, state_next;
  logic [13:0] addr_reg, addr_next;
  logic [14:0] count_reg, count_next;
  logic        full_reg, full_next;
  logic        err_reg, err_next;
  logic        we_reg, we_next;
  logic [13:0] waddr_reg, waddr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic [31:0] enc_word;
  logic        illegal;
  logic        accept;
  logic        do_write;

  // R-type word: SPECIAL opcode with all five fields supplied by the caller
  function automatic logic [31:0] r_fmt(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                        input logic [4:0] f_rd, input logic [4:0] f_sh,
                                        input logic [5:0] f_fn);
    return {6'b000000, f_rs, f_rt, f_rd, f_sh, f_fn};
  endfunction

  // I-type word: opcode, rs, rt and a 16-bit immediate
  function automatic logic [31:0] i_fmt(input logic [5:0] f_op, input logic [4:0] f_rs,
                                        input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {f_op, f_rs, f_rt, f_imm};
  endfunction

  // Combinational encoder: unused fields are forced to zero per instruction format
  always_comb begin
    enc_word = 32'h0000_0000;
    illegal  = 1'b0;
    case (mnem)
      6'd0:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h20);        // add
      6'd1:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h21);        // addu
      6'd2:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h22);        // sub
      6'd3:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h23);        // subu
      6'd4:  enc_word = r_fmt(rs, rt, 5'd0, 5'd0, 6'h18);      // mult
      6'd5:  enc_word = r_fmt(rs, rt, 5'd0, 5'd0, 6'h19);      // multu
      6'd6:  enc_word = r_fmt(rs, rt, 5'd0, 5'd0, 6'h1A);      // div
      6'd7:  enc_word = r_fmt(rs, rt, 5'd0, 5'd0, 6'h1B);      // divu
      6'd8:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h24);        // and
      6'd9:  enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h25);        // or
      6'd10: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h26);        // xor
      6'd11: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h27);        // nor
      6'd12: enc_word = i_fmt(6'h08, rs, rt, imm[15:0]);       // addi
      6'd13: enc_word = i_fmt(6'h09, rs, rt, imm[15:0]);       // addiu
      6'd14: enc_word = i_fmt(6'h0C, rs, rt, imm[15:0]);       // andi
      6'd15: enc_word = i_fmt(6'h0D, rs, rt, imm[15:0]);       // ori
      6'd16: enc_word = i_fmt(6'h0E, rs, rt, imm[15:0]);       // xori
      6'd17: enc_word = i_fmt(6'h0F, 5'd0, rt, imm[15:0]);     // lui
      6'd18: enc_word = r_fmt(5'd0, rt, rd, shamt, 6'h00);     // sll
      6'd19: enc_word = r_fmt(5'd0, rt, rd, shamt, 6'h02);     // srl
      6'd20: enc_word = r_fmt(5'd0, rt, rd, shamt, 6'h03);     // sra
      6'd21: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h04);        // sllv
      6'd22: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h06);        // srlv
      6'd23: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h07);        // srav
      6'd24: enc_word = i_fmt(6'h20, rs, rt, imm[15:0]);       // lb
      6'd25: enc_word = i_fmt(6'h24, rs, rt, imm[15:0]);       // lbu
      6'd26: enc_word = i_fmt(6'h21, rs, rt, imm[15:0]);       // lh
      6'd27: enc_word = i_fmt(6'h25, rs, rt, imm[15:0]);       // lhu
      6'd28: enc_word = i_fmt(6'h23, rs, rt, imm[15:0]);       // lw
      6'd29: enc_word = i_fmt(6'h28, rs, rt, imm[15:0]);       // sb
      6'd30: enc_word = i_fmt(6'h29, rs, rt, imm[15:0]);       // sh
      6'd31: enc_word = i_fmt(6'h2B, rs, rt, imm[15:0]);       // sw
      6'd32: enc_word = i_fmt(6'h04, rs, rt, imm[15:0]);       // beq
      6'd33: enc_word = i_fmt(6'h05, rs, rt, imm[15:0]);       // bne
      6'd34: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h2A);        // slt
      6'd35: enc_word = i_fmt(6'h0A, rs, rt, imm[15:0]);       // slti
      6'd36: enc_word = r_fmt(rs, rt, rd, 5'd0, 6'h2B);        // sltu
      6'd37: enc_word = i_fmt(6'h0B, rs, rt, imm[15:0]);       // sltiu
      6'd38: enc_word = i_fmt(6'h01, rs, 5'b00001, imm[15:0]); // bgez
      6'd39: enc_word = i_fmt(6'h07, rs, 5'd0, imm[15:0]);     // bgtz
      6'd40: enc_word = i_fmt(6'h06, rs, 5'd0, imm[15:0]);     // blez
      6'd41: enc_word = i_fmt(6'h01, rs, 5'b00000, imm[15:0]); // bltz
      6'd42: enc_word = i_fmt(6'h01, rs, 5'b10001, imm[15:0]); // bgezal
      6'd43: enc_word = i_fmt(6'h01, rs, 5'b10000, imm[15:0]); // bltzal
      6'd44: enc_word = {6'h02, imm};                          // j
      6'd45: enc_word = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h08);    // jr
      6'd46: enc_word = {6'h03, imm};                          // jal
      6'd47: enc_word = r_fmt(rs, 5'd0, rd, 5'd0, 6'h09);      // jalr
      6'd48: enc_word = r_fmt(5'd0, 5'd0, rd, 5'd0, 6'h10);    // mfhi
      6'd49: enc_word = r_fmt(5'd0, 5'd0, rd, 5'd0, 6'h12);    // mflo
      6'd50: enc_word = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h11);    // mthi
      6'd51: enc_word = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h13);    // mtlo
      6'd52: enc_word = {26'd0, 6'h0D};                        // break
      6'd53: enc_word = {26'd0, 6'h0C};                        // syscall
      6'd54: enc_word = 32'h4200_0018;                         // eret
      6'd55: enc_word = {6'h10, 5'b00000, rt, rd, 11'd0};      // mfc0
      6'd56: enc_word = {6'h10, 5'b00100, rt, rd, 11'd0};      // mtc0
      default: illegal = 1'b1;
    endcase
  end

  assign in_ready = (state_reg == RUN);
  assign accept   = in_valid && in_ready;
  // In halt mode an illegal beat is consumed but never written
  assign do_write = accept && !(HALT_ON_ILLEGAL && illegal);

  // Next-state, address/count bookkeeping and write-port staging
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    full_next  = full_reg;
    err_next   = HALT_ON_ILLEGAL ? err_reg : 1'b0;
    we_next    = do_write;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;

    if (do_write) begin
      waddr_next = addr_reg;
      wdata_next = illegal ? 32'h0000_0000 : enc_word;
    end

    if (start) begin
      // start wins over stop and restarts from base_addr in any state
      addr_next  = base_addr;
      count_next = '0;
      err_next   = 1'b0;
      if (base_addr > limit) begin
        state_next = FULL;
        full_next  = 1'b1;
      end else begin
        state_next = RUN;
        full_next  = 1'b0;
      end
    end else begin
      if (do_write) begin
        count_next = count_reg + 15'd1;
        // The address parks at limit instead of wrapping
        if (addr_reg == limit) begin
          state_next = FULL;
          full_next  = 1'b1;
        end else begin
          addr_next = addr_reg + 14'd1;
        end
      end
      if (accept && illegal) begin
        err_next = 1'b1;
        if (HALT_ON_ILLEGAL) state_next = ERR;
      end
      if (stop && (state_reg != IDLE)) state_next = IDLE;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      full_reg  <= full_next;
      err_reg   <= err_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = waddr_reg;
  assign imem_wdata = wdata_reg;
  assign count      = count_reg;
  assign full       = full_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a transaction-level model predicts every output
// each cycle from the encoding table and writer rules; directed literals pin
// the model. Honours ENC_ERR_HALT_EN the same way the design does.
module tb_instr_encoder;

`ifdef ENC_ERR_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start, stop, in_valid, in_ready;
  logic [13:0] base_addr, limit;
  logic [5:0]  mnem;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] imm;
  logic        imem_we, full, err;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [14:0] count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .base_addr(base_addr), .limit(limit),
    .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- encoding table (field-keep masks) ----------------
  localparam int K_RS = 1, K_RT = 2, K_RD = 4, K_SH = 8, K_I16 = 16, K_I26 = 32, K_FN = 64;
  localparam int R3 = K_RS | K_RT | K_RD | K_FN;
  localparam int MD = K_RS | K_RT | K_FN;
  localparam int SH = K_RT | K_RD | K_SH | K_FN;
  localparam int IT = K_RS | K_RT | K_I16;
  localparam int BR = K_RS | K_I16;

  int t_op [64];
  int t_fn [64];
  int t_keep [64];
  int t_rsf [64];
  int t_rtf [64];

  task automatic t(input int c, input int op, input int fn, input int keep, input int rsf, input int rtf);
    t_op[c] = op; t_fn[c] = fn; t_keep[c] = keep; t_rsf[c] = rsf; t_rtf[c] = rtf;
  endtask

  task automatic init_table();
    t(0, 0, 'h20, R3, 0, 0);  t(1, 0, 'h21, R3, 0, 0);  t(2, 0, 'h22, R3, 0, 0);  t(3, 0, 'h23, R3, 0, 0);
    t(4, 0, 'h18, MD, 0, 0);  t(5, 0, 'h19, MD, 0, 0);  t(6, 0, 'h1A, MD, 0, 0);  t(7, 0, 'h1B, MD, 0, 0);
    t(8, 0, 'h24, R3, 0, 0);  t(9, 0, 'h25, R3, 0, 0);  t(10, 0, 'h26, R3, 0, 0); t(11, 0, 'h27, R3, 0, 0);
    t(12, 'h08, 0, IT, 0, 0); t(13, 'h09, 0, IT, 0, 0); t(14, 'h0C, 0, IT, 0, 0); t(15, 'h0D, 0, IT, 0, 0);
    t(16, 'h0E, 0, IT, 0, 0); t(17, 'h0F, 0, K_RT | K_I16, 0, 0);
    t(18, 0, 'h00, SH, 0, 0); t(19, 0, 'h02, SH, 0, 0); t(20, 0, 'h03, SH, 0, 0);
    t(21, 0, 'h04, R3, 0, 0); t(22, 0, 'h06, R3, 0, 0); t(23, 0, 'h07, R3, 0, 0);
    t(24, 'h20, 0, IT, 0, 0); t(25, 'h24, 0, IT, 0, 0); t(26, 'h21, 0, IT, 0, 0); t(27, 'h25, 0, IT, 0, 0);
    t(28, 'h23, 0, IT, 0, 0); t(29, 'h28, 0, IT, 0, 0); t(30, 'h29, 0, IT, 0, 0); t(31, 'h2B, 0, IT, 0, 0);
    t(32, 'h04, 0, IT, 0, 0); t(33, 'h05, 0, IT, 0, 0); t(34, 0, 'h2A, R3, 0, 0); t(35, 'h0A, 0, IT, 0, 0);
    t(36, 0, 'h2B, R3, 0, 0); t(37, 'h0B, 0, IT, 0, 0);
    t(38, 1, 0, BR, 0, 1);    t(39, 'h07, 0, BR, 0, 0); t(40, 'h06, 0, BR, 0, 0); t(41, 1, 0, BR, 0, 0);
    t(42, 1, 0, BR, 0, 17);   t(43, 1, 0, BR, 0, 16);
    t(44, 2, 0, K_I26, 0, 0); t(45, 0, 'h08, K_RS | K_FN, 0, 0); t(46, 3, 0, K_I26, 0, 0);
    t(47, 0, 'h09, K_RS | K_RD | K_FN, 0, 0);
    t(48, 0, 'h10, K_RD | K_FN, 0, 0); t(49, 0, 'h12, K_RD | K_FN, 0, 0);
    t(50, 0, 'h11, K_RS | K_FN, 0, 0); t(51, 0, 'h13, K_RS | K_FN, 0, 0);
    t(52, 0, 'h0D, K_FN, 0, 0); t(53, 0, 'h0C, K_FN, 0, 0);
    t(54, 'h10, 'h18, K_FN, 16, 0);
    t(55, 'h10, 0, K_RT | K_RD, 0, 0); t(56, 'h10, 0, K_RT | K_RD, 4, 0);
  endtask

  function automatic logic [31:0] ref_enc(input int c, input logic [4:0] f_rs, input logic [4:0] f_rt,
                                          input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [25:0] f_imm);
    logic [31:0] w;
    int k;
    if (c > 56) return 32'h0;
    k = t_keep[c];
    w = 32'(t_op[c]) << 26;
    w |= ((k & K_RS) != 0) ? (32'(f_rs) << 21) : (32'(t_rsf[c]) << 21);
    w |= ((k & K_RT) != 0) ? (32'(f_rt) << 16) : (32'(t_rtf[c]) << 16);
    if ((k & K_RD) != 0)  w |= 32'(f_rd) << 11;
    if ((k & K_SH) != 0)  w |= 32'(f_sh) << 6;
    if ((k & K_I16) != 0) w |= 32'(f_imm[15:0]);
    if ((k & K_I26) != 0) w |= 32'(f_imm);
    if ((k & K_FN) != 0)  w |= 32'(t_fn[c]);
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 full, 3 halted on error
  int          m_mode;
  int          m_addr, m_count;
  logic        m_full, m_err, m_we;
  logic [13:0] m_waddr;
  logic [31:0] m_wdata;
  int          cyc = 0;

  // Advance the model at every clock edge; reset clears it asynchronously
  always @(posedge clk or posedge rst) begin
    bit acc, ill, wrote;
    if (rst) begin
      m_mode = 0; m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      cyc++;
      acc   = in_valid && (m_mode == 1);
      ill   = (int'(mnem) > 56);
      wrote = acc && !(HALT && ill);
      m_we  = wrote;
      if (wrote) begin
        m_waddr = 14'(m_addr);
        m_wdata = ref_enc(int'(mnem), rs, rt, rd, shamt, imm);
      end
      if (!HALT) m_err = acc && ill;
      if (start) begin
        m_addr = int'(base_addr); m_count = 0; m_err = 0;
        m_full = (base_addr > limit);
        m_mode = m_full ? 2 : 1;
      end else begin
        if (wrote) begin
          m_count++;
          if (m_addr == int'(limit)) begin m_mode = 2; m_full = 1; end
          else m_addr++;
        end
        if (HALT && acc && ill) begin m_mode = 3; m_err = 1; end
        if (stop && m_mode != 0) m_mode = 0;
      end
    end
  end

  typedef struct { int c; logic [13:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];

  // Compare every output against the model on the falling edge; log writes
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_mode == 1));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    chk("imem_addr", 32'(imem_addr), 32'(m_waddr));
    chk("imem_wdata", imem_wdata, m_wdata);
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_full));
    chk("err", 32'(err), 32'(m_err));
    if (imem_we) wlog.push_back('{cyc, imem_addr, imem_wdata});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic pulse_start(); start = 1; step(); start = 0; endtask
  task automatic pulse_stop();  stop = 1;  step(); stop = 0;  endtask
  task automatic idle(); in_valid = 0; step(); endtask
  task automatic beat(input int c, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic [4:0] s, input logic [25:0] i);
    in_valid = 1; mnem = 6'(c); rs = a; rt = b; rd = d; shamt = s; imm = i;
    step();
  endtask

  int n0;

  initial begin
    init_table();
    start = 0; stop = 0; in_valid = 0; base_addr = 0; limit = 0;
    mnem = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0;
    #1 rst = 1;
    #2;
    repeat (2) step();
    rst = 0;
    chk("rst_we", 32'(imem_we), 0); chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0); chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 0); chk("rst_full_err", 32'({full, err}), 0);

    // single add at 0x010
    base_addr = 14'h010; limit = 14'h0FF;
    pulse_start();
    chk("ready_after_start", 32'(in_ready), 1);
    n0 = wlog.size();
    beat(0, 1, 2, 3, 0, 0); idle();
    chk("add_nwr", 32'(wlog.size() - n0), 1);
    chk("add_addr", 32'(wlog[n0].a), 32'h010);
    chk("add_data", wlog[n0].d, 32'h00221820);
    chk("add_count", 32'(count), 1);

    // back-to-back addi, j, bgezal
    n0 = wlog.size();
    beat(12, 0, 8, 0, 0, 26'h5); beat(44, 0, 0, 0, 0, 26'h40); beat(42, 4, 0, 0, 0, 26'hFFFF); idle();
    chk("b2b_nwr", 32'(wlog.size() - n0), 3);
    chk("b2b_d0", wlog[n0].d, 32'h20080005);
    chk("b2b_d1", wlog[n0+1].d, 32'h08000040);
    chk("b2b_d2", wlog[n0+2].d, 32'h0491FFFF);
    chk("b2b_a0", 32'(wlog[n0].a), 32'h011);
    chk("b2b_a2", 32'(wlog[n0+2].a), 32'h013);
    chk("b2b_gap1", 32'(wlog[n0+1].c - wlog[n0].c), 1);
    chk("b2b_gap2", 32'(wlog[n0+2].c - wlog[n0+1].c), 1);

    // eret with garbage fields, mtc0, jr, lui
    n0 = wlog.size();
    beat(54, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 26'h3FFFFFF);
    beat(56, 0, 5, 12, 0, 0);
    beat(45, 31, 7, 9, 3, 26'h3FFFFFF);
    beat(17, 5, 1, 0, 0, 26'h1234);
    idle();
    chk("eret", wlog[n0].d, 32'h42000018);
    chk("mtc0", wlog[n0+1].d, 32'h40856000);
    chk("jr", wlog[n0+2].d, 32'h03E00008);
    chk("lui", wlog[n0+3].d, 32'h3C011234);
    chk("cop_count", 32'(count), 8);

    // sweep every legal mnemonic, back to back, from a fresh base
    base_addr = 14'h100; limit = 14'h3FF;
    pulse_start();
    n0 = wlog.size();
    for (int c = 0; c <= 56; c++)
      beat(c, 5'(c * 7 + 3), 5'(c * 11 + 1), 5'(c * 13 + 5), 5'(c + 9), 26'(c * 32'h01234567 ^ 32'h2AAAAAA));
    idle();
    chk("sweep_nwr", 32'(wlog.size() - n0), 57);
    chk("sweep_count", 32'(count), 57);
    chk("sweep_last_addr", 32'(imem_addr), 32'h138);

    // illegal mnemonic
    n0 = wlog.size();
    beat(60, 1, 2, 3, 4, 26'h123);
`ifdef ENC_ERR_HALT_EN
    chk("ill_we", 32'(imem_we), 0);
    chk("ill_err", 32'(err), 1);
    chk("ill_ready", 32'(in_ready), 0);
    beat(0, 1, 2, 3, 0, 0); idle();
    chk("ill_nwr", 32'(wlog.size() - n0), 0);
    chk("ill_ready_hold", 32'(in_ready), 0);
    pulse_stop();
    chk("ill_err_after_stop", 32'(err), 1);
`else
    chk("ill_we", 32'(imem_we), 1);
    chk("ill_wdata", imem_wdata, 32'h0);
    chk("ill_err", 32'(err), 1);
    idle();
    chk("ill_err_pulse", 32'(err), 0);
    chk("ill_nwr", 32'(wlog.size() - n0), 1);
    chk("ill_count", 32'(count), 58);
`endif

    // single-word window at the top of memory
    base_addr = 14'h3FFF; limit = 14'h3FFF;
    pulse_start();
    n0 = wlog.size();
    beat(1, 1, 1, 1, 0, 0); beat(2, 2, 2, 2, 0, 0); beat(3, 3, 3, 3, 0, 0); idle();
    chk("lim_nwr", 32'(wlog.size() - n0), 1);
    chk("lim_addr", 32'(wlog[n0].a), 32'h3FFF);
    chk("lim_full", 32'(full), 1);
    chk("lim_ready", 32'(in_ready), 0);
    chk("lim_count", 32'(count), 1);
    pulse_stop();
    chk("stop_full_hold", 32'(full), 1);
    chk("stop_count_hold", 32'(count), 1);

    // base beyond limit: straight to FULL
    base_addr = 14'h020; limit = 14'h010;
    pulse_start();
    n0 = wlog.size();
    beat(0, 1, 1, 1, 0, 0); beat(0, 1, 1, 1, 0, 0); idle();
    chk("inv_nwr", 32'(wlog.size() - n0), 0);
    chk("inv_full", 32'(full), 1);
    chk("inv_count", 32'(count), 0);

    // asynchronous reset while a write is on the port
    base_addr = 14'h200; limit = 14'h3FF;
    pulse_start();
    beat(0, 1, 2, 3, 0, 0);
    chk("pre_rst_we", 32'(imem_we), 1);
    #2 rst = 1;
    #1;
    chk("arst_we", 32'(imem_we), 0); chk("arst_addr", 32'(imem_addr), 0);
    chk("arst_wdata", imem_wdata, 0); chk("arst_count", 32'(count), 0);
    chk("arst_ready", 32'(in_ready), 0); chk("arst_full_err", 32'({full, err}), 0);
    n0 = wlog.size();
    repeat (2) step();
    rst = 0;
    repeat (4) step();
    chk("post_rst_nwr", 32'(wlog.size() - n0), 0);
    in_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
